// File: rtl/tinker_muldiv_unit_if.sv
// rtl/tinker_muldiv_unit_if.sv - operation request and result handshake bundle for the mul/div unit
interface tinker_muldiv_unit_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_signed;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;

  modport master (
    output in_valid, in_op, in_signed, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_dbz
  );

  modport slave (
    input  in_valid, in_op, in_signed, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_dbz
  );
endinterface

// File: rtl/tinker_muldiv_unit.sv
// rtl/tinker_muldiv_unit.sv - iterative radix-2 multiply/divide unit (shift-add MUL, restoring DIV)
module tinker_muldiv_unit #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  tinker_muldiv_unit_if.slave md,
  output logic                busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               b_zero;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   final_result;

  always_comb begin
    a_neg  = md.in_signed & md.in_a[WIDTH-1];
    b_neg  = md.in_signed & md.in_b[WIDTH-1];
    a_mag  = a_neg ? -md.in_a : md.in_a;
    b_mag  = b_neg ? -md.in_b : md.in_b;
    b_zero = (md.in_b == '0);
  end

  // acc holds the product for MUL/MULH and {partial remainder, quotient/dividend} for DIV/REM
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    acc_next  = op[1] ? div_next : mul_next;
    prod      = (sa ^ sb) ? -mul_next : mul_next;
    quo       = (sa ^ sb) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem       = sa ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    case (op)
      2'b00:   final_result = prod[WIDTH-1:0];
      2'b01:   final_result = prod[2*WIDTH-1:WIDTH];
      2'b10:   final_result = quo;
      default: final_result = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op            <= 2'b00;
      sa            <= 1'b0;
      sb            <= 1'b0;
      mag_b         <= '0;
      acc           <= '0;
      md.in_ready   <= 1'b1;
      md.out_valid  <= 1'b0;
      md.out_result <= '0;
      md.out_tag    <= '0;
      md.out_dbz    <= 1'b0;
      busy          <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      cnt          <= '0;
      md.in_ready  <= 1'b1;
      md.out_valid <= 1'b0;
      md.out_dbz   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md.in_valid) begin
            op          <= md.in_op;
            sa          <= a_neg;
            sb          <= b_neg;
            mag_b       <= b_mag;
            md.out_tag  <= md.in_tag;
            md.in_ready <= 1'b0;
            busy        <= 1'b1;
            // Divide by zero skips the iterations: DIV yields 0, REM echoes the raw dividend
            if (md.in_op[1] && b_zero) begin
              state         <= DONE;
              md.out_valid  <= 1'b1;
              md.out_dbz    <= 1'b1;
              md.out_result <= md.in_op[0] ? md.in_a : '0;
            end else begin
              state      <= CALC;
              cnt        <= CNT_W'(WIDTH);
              acc        <= {{WIDTH{1'b0}}, a_mag};
              md.out_dbz <= 1'b0;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state         <= DONE;
            md.out_result <= final_result;
            md.out_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (md.out_ready) begin
            state        <= IDLE;
            md.out_valid <= 1'b0;
            md.out_dbz   <= 1'b0;
            md.in_ready  <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
